// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding and error-cause constants for the stall sequencer
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    IWAIT = 2'd2,
    ERR   = 2'd3
  } pipe_state_e;

  localparam logic ERR_CAUSE_IMEM = 1'b0;
  localparam logic ERR_CAUSE_DMEM = 1'b1;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - saturating wait-cycle timer with timeout compare, shared by both memory waits
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 64,
  parameter int TMR_W       = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic inc,
  output logic timeout
);

  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(MEM_TIMEOUT);

  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_inc;

  assign timer_inc = (&timer) ? timer : timer + 1'b1;

  // Fires in the wait cycle whose completion brings the count to the limit
  assign timeout = (MEM_TIMEOUT != 0) && inc && (timer_inc >= LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (start) begin
      timer <= TMR_W'(1);
    end else if (inc) begin
      timer <= timer_inc;
    end else begin
      timer <= '0;
    end
  end

endmodule

// File: rtl/pipeline_stall_sequencer.sv
// rtl/pipeline_stall_sequencer.sv - RV32I stall/flush sequencer; optional STALL_PERF_EN adds stall/flush counters
module pipeline_stall_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int TMR_W       = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_use,
  input  logic redirect,
  input  logic dmem_req,
  input  logic dmem_ready,
  input  logic imem_ready,
  output logic pc_write,
  output logic ifid_write,
  output logic ifid_flush,
  output logic idex_write,
  output logic idex_bubble,
  output logic exmem_write,
  output logic memwb_bubble,
  output logic bus_err,
  output logic err_cause
`ifdef STALL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles
`endif
);

  pipe_state_e state, state_n;
  logic tmr_start, tmr_inc, timeout;
  logic err_set, cause_n;
  logic front_eval, redirect_flush;
  logic dmem_stall;

  assign dmem_stall = dmem_req & ~dmem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TMR_W      (TMR_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (tmr_start),
    .inc    (tmr_inc),
    .timeout(timeout)
  );

  always_comb begin
    pc_write       = 1'b1;
    ifid_write     = 1'b1;
    ifid_flush     = 1'b0;
    idex_write     = 1'b1;
    idex_bubble    = 1'b0;
    exmem_write    = 1'b1;
    memwb_bubble   = 1'b0;
    state_n        = state;
    tmr_start      = 1'b0;
    tmr_inc        = 1'b0;
    err_set        = 1'b0;
    cause_n        = ERR_CAUSE_IMEM;
    front_eval     = 1'b0;
    redirect_flush = 1'b0;

    case (state)
      RUN: begin
        if (dmem_stall) begin
          {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
          memwb_bubble = 1'b1;
          state_n      = DWAIT;
          tmr_start    = 1'b1;
        end else begin
          front_eval = 1'b1;
        end
      end
      DWAIT: begin
        if (!dmem_ready) begin
          {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
          memwb_bubble = 1'b1;
          tmr_inc      = 1'b1;
          if (timeout) begin
            state_n = ERR;
            err_set = 1'b1;
            cause_n = ERR_CAUSE_DMEM;
          end
        end else begin
          state_n    = RUN;
          front_eval = 1'b1;
        end
      end
      IWAIT: begin
        if (dmem_stall) begin
          {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
          memwb_bubble = 1'b1;
          state_n      = DWAIT;
          tmr_start    = 1'b1;
        end else if (redirect) begin
          // Fetch is restartable, so the pending access is simply dropped
          ifid_flush     = 1'b1;
          idex_bubble    = 1'b1;
          redirect_flush = 1'b1;
          state_n        = RUN;
        end else if (!imem_ready) begin
          pc_write   = 1'b0;
          ifid_flush = 1'b1;
          tmr_inc    = 1'b1;
          if (timeout) begin
            state_n = ERR;
            err_set = 1'b1;
            cause_n = ERR_CAUSE_IMEM;
          end
        end else begin
          state_n = RUN;
        end
      end
      default: begin
        {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
        {ifid_flush, idex_bubble, memwb_bubble}         = 3'b111;
      end
    endcase

    if (front_eval) begin
      if (redirect) begin
        ifid_flush     = 1'b1;
        idex_bubble    = 1'b1;
        redirect_flush = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end else if (!imem_ready) begin
        pc_write   = 1'b0;
        ifid_flush = 1'b1;
        state_n    = IWAIT;
        tmr_start  = 1'b1;
      end
    end

    if (!rst_n) begin
      {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
      {ifid_flush, idex_bubble, memwb_bubble}         = 3'b111;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      bus_err   <= 1'b0;
      err_cause <= 1'b0;
    end else begin
      state <= state_n;
      if (err_set) begin
        bus_err   <= 1'b1;
        err_cause <= cause_n;
      end
    end
  end

`ifdef STALL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (!pc_write && state != ERR) stall_cycles <= stall_cycles + 32'd1;
      if (redirect_flush) flush_cycles <= flush_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// tb/tb_pipeline_stall_sequencer.sv - directed scoreboard bench for pipeline_stall_sequencer
module tb_pipeline_stall_sequencer;

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble, bus_err, err_cause}
  localparam logic [8:0] V_DEF  = 9'b110101000;
  localparam logic [8:0] V_LU   = 9'b000111000;
  localparam logic [8:0] V_RED  = 9'b111111000;
  localparam logic [8:0] V_FRZ  = 9'b000000100;
  localparam logic [8:0] V_IW   = 9'b011101000;
  localparam logic [8:0] V_RST  = 9'b001010100;
  localparam logic [8:0] V_ERRD = 9'b001010111;
  localparam logic [8:0] V_ERRI = 9'b001010110;

  logic clk = 1'b0;
  logic rst_n, load_use, redirect, dmem_req, dmem_ready, imem_ready;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
  logic exmem_write, memwb_bubble, bus_err, err_cause;
`ifdef STALL_PERF_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  pipeline_stall_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_use    (load_use),
    .redirect    (redirect),
    .dmem_req    (dmem_req),
    .dmem_ready  (dmem_ready),
    .imem_ready  (imem_ready),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .ifid_flush  (ifid_flush),
    .idex_write  (idex_write),
    .idex_bubble (idex_bubble),
    .exmem_write (exmem_write),
    .memwb_bubble(memwb_bubble),
    .bus_err     (bus_err),
    .err_cause   (err_cause)
`ifdef STALL_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_cycles(flush_cycles)
`endif
  );

  // Drive one cycle of inputs at negedge, queue the expected outputs, compare mid-cycle
  task automatic step(input string tag, input logic rn, input logic lu, input logic rd,
                      input logic dq, input logic dr, input logic ir, input logic [8:0] expv);
    logic [8:0] obs;
    logic [8:0] want;
    @(negedge clk);
    rst_n      = rn;
    load_use   = lu;
    redirect   = rd;
    dmem_req   = dq;
    dmem_ready = dr;
    imem_ready = ir;
    exp_q.push_back(expv);
    #2;
    obs  = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
            exmem_write, memwb_bubble, bus_err, err_cause};
    want = exp_q.pop_front();
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
  endtask

  initial begin
    rst_n = 1'b0; load_use = 1'b0; redirect = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1;

    //    tag             rn lu rd dq dr ir  expected
    step("reset_hold",    0, 0, 0, 0, 1, 1, V_RST);
    step("reset_hold2",   0, 0, 0, 0, 1, 1, V_RST);
    step("idle",          1, 0, 0, 0, 1, 1, V_DEF);
    step("load_use",      1, 1, 0, 0, 1, 1, V_LU);
    step("after_lu",      1, 0, 0, 0, 1, 1, V_DEF);
    step("redir_lu",      1, 1, 1, 0, 1, 1, V_RED);
    step("dwait_1",       1, 0, 0, 1, 0, 1, V_FRZ);
    step("dwait_2_redir", 1, 0, 1, 1, 0, 1, V_FRZ);
    step("dwait_3",       1, 0, 0, 1, 0, 1, V_FRZ);
    step("dwait_release", 1, 0, 0, 1, 1, 1, V_DEF);
    step("back_in_run",   1, 0, 0, 0, 1, 1, V_DEF);
    step("iwait_1",       1, 0, 0, 0, 1, 0, V_IW);
    step("iwait_redir",   1, 0, 1, 0, 1, 0, V_RED);
    step("after_iredir",  1, 0, 0, 0, 1, 1, V_DEF);
    step("iwait_a",       1, 0, 0, 0, 1, 0, V_IW);
    step("iwait_lu",      1, 1, 0, 0, 1, 0, V_IW);
    step("iwait_done",    1, 0, 0, 0, 1, 1, V_DEF);
    step("run_again",     1, 0, 0, 0, 1, 1, V_DEF);
    step("dmiss",         1, 0, 0, 1, 0, 1, V_FRZ);
    step("dready_imiss",  1, 0, 0, 1, 1, 0, V_IW);
    step("iwait_from_d",  1, 0, 0, 0, 1, 0, V_IW);
    step("iwait_from_d2", 1, 0, 0, 0, 1, 1, V_DEF);
    // Data timeout: four frozen cycles, then ERR with cause = data
    step("dto_1",         1, 0, 0, 1, 0, 1, V_FRZ);
    step("dto_2",         1, 0, 0, 1, 0, 1, V_FRZ);
    step("dto_3",         1, 0, 0, 1, 0, 1, V_FRZ);
    step("dto_4",         1, 0, 0, 1, 0, 1, V_FRZ);
    step("derr",          1, 0, 0, 1, 1, 1, V_ERRD);
    step("derr_held",     1, 1, 1, 0, 1, 1, V_ERRD);
    step("derr_rst_cyc",  0, 0, 0, 0, 1, 1, V_RST | 9'b000000011);
    step("derr_rst_done", 0, 0, 0, 0, 1, 1, V_RST);
    // Ready arriving in the cycle that would time out wins
    step("race_1",        1, 0, 0, 1, 0, 1, V_FRZ);
    step("race_2",        1, 0, 0, 1, 0, 1, V_FRZ);
    step("race_3",        1, 0, 0, 1, 0, 1, V_FRZ);
    step("race_ready",    1, 0, 0, 1, 1, 1, V_DEF);
    step("race_no_err",   1, 0, 0, 0, 1, 1, V_DEF);
    // Instruction timeout: cause = instruction
    step("ito_1",         1, 0, 0, 0, 1, 0, V_IW);
    step("ito_2",         1, 0, 0, 0, 1, 0, V_IW);
    step("ito_3",         1, 0, 0, 0, 1, 0, V_IW);
    step("ito_4",         1, 0, 0, 0, 1, 0, V_IW);
    step("ierr",          1, 0, 0, 0, 1, 1, V_ERRI);
    step("ierr_rst_cyc",  0, 0, 0, 0, 1, 1, V_ERRI);
    step("ierr_rst_done", 0, 0, 0, 0, 1, 1, V_RST);
    // Reset in the middle of a data wait
    step("mid_1",         1, 0, 0, 1, 0, 1, V_FRZ);
    step("mid_2",         1, 0, 0, 1, 0, 1, V_FRZ);
    step("mid_rst",       0, 0, 0, 1, 0, 1, V_RST);
    step("mid_released",  1, 0, 0, 0, 1, 1, V_DEF);
`ifdef STALL_PERF_EN
    n_checks++;
    assert (stall_cycles === 32'd0) else begin
      n_fail++;
      $error("FAIL stall_cycles_after_reset observed=%0d expected=0", stall_cycles);
    end
`endif
    step("mid_run",       1, 1, 0, 0, 1, 1, V_LU);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
